// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// reset/exception vectors and mult/div busy-window lengths.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    MDWAIT = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC    = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR  = 32'h0000_4180;
  localparam int          MULT_CYCLES = 5;
  localparam int          DIV_CYCLES  = 10;
  localparam int          CNT_W       = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: PC/branch/mult-div inputs and the PC/pipeline enables.
// misalign exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_ctrl_if;
  logic [31:0] pc;
  logic        hz_stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        md_start;
  logic        md_is_div;
  logic        md_use;
  logic        PC_en;
  logic [31:0] nextPC;
  logic        F_D_en;
  logic        D_E_clr;
  logic        md_busy;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
`endif

  modport master (
`ifdef FETCH_ALIGN_CHECK_EN
    input  misalign,
`endif
    output pc, hz_stall, br_valid, br_target, md_start, md_is_div, md_use,
    input  PC_en, nextPC, F_D_en, D_E_clr, md_busy
  );

  modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
    output misalign,
`endif
    input  pc, hz_stall, br_valid, br_target, md_start, md_is_div, md_use,
    output PC_en, nextPC, F_D_en, D_E_clr, md_busy
  );
endinterface

// File: rtl/md_busy_cnt.sv
// Mult/div busy-window counter: load on issue, decrement while waiting.
// Busy flag is high whenever the count is non-zero.
module md_busy_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         busy
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer: boot stall, hazard and mult/div stalls, branch redirect mux.
// FETCH_ALIGN_CHECK_EN: misaligned redirects go to the exception vector.
module fetch_ctrl
  import cpu_pkg::*;
(
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.slave bus
);

  localparam logic [1:0] S_BOOT   = BOOT;
  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_MDWAIT = MDWAIT;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_busy;
  logic             in_boot;
  logic             in_mdwait;
  logic             md_load;
  logic             stall;
  logic             redirect;
  logic [31:0]      pc_inc;

  assign in_boot   = (state_q == S_BOOT);
  assign in_mdwait = (state_q == S_MDWAIT);
  // A second issue inside the window is deliberately not reloaded.
  assign md_load   = (state_q == S_RUN) && bus.md_start;

  md_busy_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (md_load),
    .load_val (bus.md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
    .dec      (in_mdwait),
    .cnt      (cnt),
    .busy     (cnt_busy)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:   state_d = S_RUN;
      S_RUN:    if (bus.md_start) state_d = S_MDWAIT;
      S_MDWAIT: if ((cnt == CNT_W'(1) || !cnt_busy) && !bus.md_start) state_d = S_RUN;
      default:  state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // Outputs are forced to their reset values while reset is held low.
  assign bus.md_busy = reset && (in_mdwait || bus.md_start);
  assign stall       = !reset || bus.hz_stall || (bus.md_use && bus.md_busy) || in_boot;
  assign redirect    = bus.br_valid && !stall;
  assign pc_inc      = bus.pc + 32'd4;

  assign bus.PC_en   = !stall;
  assign bus.F_D_en  = !stall;
  assign bus.D_E_clr = stall;

`ifdef FETCH_ALIGN_CHECK_EN
  logic bad_tgt;
  assign bad_tgt      = redirect && (bus.br_target[1:0] != 2'b00);
  assign bus.misalign = bad_tgt;
  assign bus.nextPC   = !reset   ? RESET_PC   :
                        bad_tgt  ? EXC_VECTOR :
                        redirect ? bus.br_target : pc_inc;
`else
  assign bus.nextPC   = !reset   ? RESET_PC      :
                        redirect ? bus.br_target : pc_inc;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expectations queued at drive time, popped
// and checked on the falling edge.
module tb_fetch_ctrl;

  typedef struct packed {
    logic        pc_en;
    logic [31:0] npc;
    logic        busy;
    logic        mis;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic pc_en, input logic [31:0] npc,
                              input logic busy, input logic mis);
    exp_t e;
    e.pc_en = pc_en;
    e.npc   = npc;
    e.busy  = busy;
    e.mis   = mis;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, ".PC_en"},   32'(bus.PC_en),   32'(e.pc_en));
    chk({tag, ".F_D_en"},  32'(bus.F_D_en),  32'(e.pc_en));
    chk({tag, ".D_E_clr"}, 32'(bus.D_E_clr), 32'(!e.pc_en));
    chk({tag, ".nextPC"},  bus.nextPC,       e.npc);
    chk({tag, ".md_busy"}, 32'(bus.md_busy), 32'(e.busy));
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, ".misalign"}, 32'(bus.misalign), 32'(e.mis));
`endif
  endtask

  task automatic drive(input logic [31:0] pc, input logic hz, input logic br,
                       input logic [31:0] tgt, input logic ms, input logic dv,
                       input logic use_md);
    bus.pc        = pc;
    bus.hz_stall  = hz;
    bus.br_valid  = br;
    bus.br_target = tgt;
    bus.md_start  = ms;
    bus.md_is_div = dv;
    bus.md_use    = use_md;
  endtask

  // Drive one cycle (called at posedge+1), check at negedge, return at next posedge+1.
  task automatic step(input string tag, input logic [31:0] pc, input logic hz,
                      input logic br, input logic [31:0] tgt, input logic ms,
                      input logic dv, input logic use_md, input exp_t e);
    drive(pc, hz, br, tgt, ms, dv, use_md);
    q.push_back(e);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div at cycle 0, optional re-issue at cycle 'again', md_use from cycle 1.
  task automatic md_window(input string tag, input logic dv, input int n, input int again);
    step({tag, ".issue"}, 32'h3020, 1'b0, 1'b0, 32'h0, 1'b1, dv, 1'b0,
         mk(1'b1, 32'h3024, 1'b1, 1'b0));
    for (int k = 1; k <= n + 1; k++) begin
      step($sformatf("%s.c%0d", tag, k), 32'h3020, 1'b0, 1'b0, 32'h0,
           (k == again), dv, 1'b1, mk(k > n, 32'h3024, k <= n, 1'b0));
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(32'h3000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    #2;
    q.push_back(mk(1'b0, 32'h3000, 1'b0, 1'b0));
    compare("rst_hold");
    @(posedge clk);
    #1;
    step("rst_edge", 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 32'h3000, 1'b0, 1'b0));

    reset = 1'b1;
    step("boot", 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 32'h3004, 1'b0, 1'b0));
    step("run0", 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h3004, 1'b0, 1'b0));

    step("br_take", 32'h3010, 1'b0, 1'b1, 32'h3040, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h3040, 1'b0, 1'b0));
    step("br_hz", 32'h3010, 1'b1, 1'b1, 32'h3040, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 32'h3014, 1'b0, 1'b0));

    md_window("div", 1'b1, 10, -1);
    md_window("mult", 1'b0, 5, -1);
    md_window("div_reissue", 1'b1, 10, 3);

    // Stall and redirect in the same cycle as a mult issue with md_use: stall wins.
    step("all_stall", 32'h3030, 1'b1, 1'b1, 32'h5000, 1'b1, 1'b0, 1'b1,
         mk(1'b0, 32'h3034, 1'b1, 1'b0));
    for (int k = 1; k <= 5; k++)
      step($sformatf("drain%0d", k), 32'h3030, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
           mk(1'b1, 32'h3034, 1'b1, 1'b0));

    step("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h0000_0000, 1'b0, 1'b0));

`ifdef FETCH_ALIGN_CHECK_EN
    step("misalign", 32'h3010, 1'b0, 1'b1, 32'h3042, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h0000_4180, 1'b0, 1'b1));
`else
    step("misalign", 32'h3010, 1'b0, 1'b1, 32'h3042, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h3042, 1'b0, 1'b0));
`endif

    step("abort_issue", 32'h3020, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0,
         mk(1'b1, 32'h3024, 1'b1, 1'b0));
    step("abort_wait", 32'h3020, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1,
         mk(1'b0, 32'h3024, 1'b1, 1'b0));
    #2;
    reset = 1'b0;
    #1;
    q.push_back(mk(1'b0, 32'h3000, 1'b0, 1'b0));
    compare("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("reboot", 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1,
         mk(1'b0, 32'h3004, 1'b0, 1'b0));
    step("reboot_run", 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1,
         mk(1'b1, 32'h3004, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
